// File: rtl/mdu_unit_pkg.sv
// Shared CPU constants for the multiply/divide unit: MDUOp encodings, latencies
// and the counter width.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 4;

  function automatic logic is_muldiv(logic [3:0] op);
    return (op >= 4'(MDU_MULT)) && (op <= 4'(MDU_DIVU));
  endfunction

  function automatic logic is_mult(logic [3:0] op);
    return (op == 4'(MDU_MULT)) || (op == 4'(MDU_MULTU));
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Pipeline-side signal bundle of the MDU. Plain level signals, no handshake:
// Start is a one-cycle pulse qualified by Busy=0 and Req=0; dbg_cnt is the
// remaining-cycle counter exposed for checkers.
interface mdu_unit_if;
  import mdu_unit_pkg::*;

  logic             Req;
  logic [3:0]       MDUOp;
  logic [31:0]      A;
  logic [31:0]      B;
  logic             Start;
  logic             Busy;
  logic [31:0]      E_MDU_result;
  logic [31:0]      HI;
  logic [31:0]      LO;
  logic [CNT_W-1:0] dbg_cnt;

  modport master (
    output Req, MDUOp, A, B,
    input  Start, Busy, E_MDU_result, HI, LO, dbg_cnt
  );

  modport slave (
    input  Req, MDUOp, A, B,
    output Start, Busy, E_MDU_result, HI, LO, dbg_cnt
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational product / quotient / remainder for the MDU.
// MDU_DIVZERO_KEEP_EN: divide by zero drops wr so HI/LO keep their old value.
module mdu_arith
  import mdu_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wr
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic        [63:0] prod_s;
  logic        [63:0] prod_u;

  assign sa     = {{32{a[31]}}, a};
  assign sb     = {{32{b[31]}}, b};
  assign prod_s = sa * sb;
  assign prod_u = {32'd0, a} * {32'd0, b};

  always_comb begin
    hi = '0;
    lo = '0;
    wr = 1'b1;
    case (op)
      MDU_MULT:  {hi, lo} = prod_s;
      MDU_MULTU: {hi, lo} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) begin
`ifdef MDU_DIVZERO_KEEP_EN
          wr = 1'b0;
`else
          hi = a;
          lo = 32'hFFFF_FFFF;
`endif
        end else if (op == 4'(MDU_DIVU)) begin
          lo = a / b;
          hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // The one signed quotient that overflows: wraps, remainder 0.
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          lo = $signed(a) / $signed(b);
          hi = $signed(a) % $signed(b);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit: result is computed at start, held pending,
// and committed to HI/LO when the latency counter expires.
module mdu_unit
  import mdu_unit_pkg::*;
(
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q, lo_q, pend_hi, pend_lo;
  logic             pend_wr;
  logic [31:0]      ar_hi, ar_lo;
  logic             ar_wr;
  logic             busy, start, mt_ok;

  mdu_arith u_arith (
    .op (bus.MDUOp),
    .a  (bus.A),
    .b  (bus.B),
    .hi (ar_hi),
    .lo (ar_lo),
    .wr (ar_wr)
  );

  assign busy  = (cnt != '0);
  assign start = is_muldiv(bus.MDUOp) && !busy && !bus.Req;
  assign mt_ok = !busy && !bus.Req;

  assign bus.Busy    = busy;
  assign bus.Start   = start;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.dbg_cnt = cnt;

  always_comb begin
    bus.E_MDU_result = '0;
    if (bus.MDUOp == 4'(MDU_MFHI)) bus.E_MDU_result = hi_q;
    else if (bus.MDUOp == 4'(MDU_MFLO)) bus.E_MDU_result = lo_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      if (start) begin
        cnt     <= is_mult(bus.MDUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        pend_hi <= ar_hi;
        pend_lo <= ar_lo;
        pend_wr <= ar_wr;
      end else if (busy) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1) && pend_wr) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
      end
      // Moves to HI/LO only happen while idle, so they never race a commit.
      if (mt_ok && bus.MDUOp == 4'(MDU_MTHI)) hi_q <= bus.A;
      if (mt_ok && bus.MDUOp == 4'(MDU_MTLO)) lo_q <= bus.A;
    end
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port Req  input  1  exception/interrupt flush; suppresses new MDU ops this cycle.
REQ-004 SHALL have port MDUOp  input  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; others = NONE.
REQ-005 SHALL have port A  input  32  forwarded rs operand.
REQ-006 SHALL have port B  input  32  forwarded rt operand.
REQ-007 SHALL have port Start  output  1  combinational; 1 when MDUOp is MULT/MULTU/DIV/DIVU, Busy=0 and Req=0.
REQ-008 SHALL have port Busy  output  1  registered; 1 while a multiply/divide is in flight.
REQ-009 SHALL have port E_MDU_result  output  32  combinational; HI for MFHI, LO for MFLO, else 0; feeds the E/M pipeline register.
REQ-010 SHALL have ports HI, LO  output  32 each  architectural registers.

Function
REQ-011 SHALL, on an edge with Start=1, capture the full result into pending registers and load the cycle counter with 5 (MULT/MULTU) or 10 (DIV/DIVU).
REQ-012 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned; HI = bits 63:32, LO = bits 31:0.
REQ-013 SHALL compute DIV as signed (quotient truncates toward zero, remainder takes the dividend's sign) and DIVU as unsigned; LO = quotient, HI = remainder.
REQ-014 SHALL drive Busy = (counter != 0), so Busy is 1 for exactly N cycles after the start edge.
REQ-015 SHALL decrement a nonzero counter on each edge; on the edge where it goes from 1 to 0, it SHALL copy the pending values into HI/LO. HI/LO are therefore first visible N edges after the start edge.
REQ-016 SHALL ignore any MULT/DIV op presented while Busy=1: no restart and no counter change. The hazard unit stalls these; the block does not rely on it.
REQ-017 SHALL write A to HI (MTHI) or to LO (MTLO) on the edge, only when Busy=0 and Req=0.
REQ-018 SHALL, for MFHI/MFLO during Busy, return the current (pre-commit) HI/LO value.
REQ-019 SHALL suppress Start, MTHI and MTLO whenever Req=1; an operation already in flight SHALL continue and commit normally.
REQ-020 SHALL handle DIV 0x8000_0000 / 0xFFFF_FFFF as LO=0x8000_0000, HI=0 (wrap, no trap).
REQ-021 SHALL leave HI/LO unaffected by MFHI, MFLO and NONE.

Reset
REQ-022 SHALL, asynchronously on reset=1, clear HI, LO, pending registers and counter to 0; Busy therefore reads 0.
REQ-023 SHALL abandon any in-flight operation on reset mid-operation, with no commit after reset releases.

Configuration
REQ-024 SHALL support macro MDU_DIVZERO_KEEP_EN. When defined, DIV/DIVU with B=0 SHALL still assert Busy for 10 cycles but leave HI/LO unchanged. When undefined, B=0 SHALL commit HI=A and LO=0xFFFF_FFFF.

Structure
REQ-025 SHALL take MDUOp encodings and latencies (MULT_CYCLES=5, DIV_CYCLES=10) from the shared CPU constants package.
REQ-026 SHALL place the combinational product/quotient/remainder computation in one sub-module, mdu_arith; counter, pending registers and HI/LO stay in mdu_unit.

Verification
REQ-027 SHALL cover: MULT A=0xFFFF_FFFE, B=3 -> Busy 5 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; MULTU same operands -> HI=0x0000_0002, LO=0xFFFF_FFFA.
REQ-028 SHALL cover: DIV A=-7 (0xFFFF_FFF9), B=2 -> Busy 10 cycles, then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; MFLO during busy returns old LO.
REQ-029 SHALL cover: MULT issued with Req=1 -> Start=0, Busy stays 0, HI/LO unchanged; MTHI 0x1234 with Req=1 -> HI unchanged.
REQ-030 SHALL cover: DIVU A=5, B=0 -> with MDU_DIVZERO_KEEP_EN, HI/LO unchanged after 10 cycles; without it, HI=5, LO=0xFFFF_FFFF.
REQ-031 SHALL cover: MULT started, reset pulsed at cycle 3 -> Busy=0 immediately, HI=LO=0, no later commit.
REQ-032 SHALL cover: second DIV presented while Busy with counter=4 -> ignored; commit at original time holds the first result.
